// File: rtl/hams_pipe_drain.sv
// Drain stage for a valid-only pipeline: buffers beats in a small circular FIFO and re-presents
// them on a valid/ready interface, throttling the producer via stop_o and flagging lost beats.
module hams_pipe_drain #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vld_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       stop_o,
  output logic                       vld_o,
  output logic [DATA_W-1:0]          data_o,
  input  logic                       rdy_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       ovf_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] StopThr = CntW'(DEPTH - PIPE_LAT);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  if (PIPE_LAT >= DEPTH || DEPTH < 2) begin : g_param_check
    $fatal(1, "hams_pipe_drain: need DEPTH >= 2 and PIPE_LAT < DEPTH");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic full;
  logic rd;
  logic wr;
  logic drop;

  assign full = (count_q == CntFull);
  assign rd   = vld_o & rdy_i;
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign wr   = vld_i & (~full | rd);
  assign drop = vld_i & full & ~rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;

    if (wr) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    case ({wr, rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign vld_o   = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign stop_o  = (count_q >= StopThr);

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntFull);

  a_vld_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
    vld_o |-> (count_q != '0));

  a_hold_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (vld_o && !rdy_i) |=> $stable(data_o));

endmodule

// File: tb/tb_hams_pipe_drain.sv
// Scoreboard bench: instance 0 is DEPTH=8 for directed cases, instance 1 is DEPTH=5 for a
// randomized run with a latency-honouring producer.
module tb_hams_pipe_drain;

  localparam int unsigned Lat = 2;

  logic        clk;
  logic        rst_n;
  logic        vld   [2];
  logic [31:0] dat   [2];
  logic        rdy   [2];
  logic        stop_w[2];
  logic        vldo_w[2];
  logic [31:0] data_w[2];
  logic        ovf_w [2];
  logic [31:0] cnt_w [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned D  = (g == 0) ? 8 : 5;
    localparam int unsigned CW = $clog2(D + 1);

    logic [CW-1:0] count;
    logic [31:0]   sb[$];
    int            cnt = 0;
    bit            ovf = 0;

    assign cnt_w[g] = 32'(count);

    hams_pipe_drain #(
      .DATA_W  (32),
      .DEPTH   (D),
      .PIPE_LAT(Lat)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (vld[g]),
      .data_i (dat[g]),
      .stop_o (stop_w[g]),
      .vld_o  (vldo_w[g]),
      .data_o (data_w[g]),
      .rdy_i  (rdy[g]),
      .count_o(count),
      .ovf_o  (ovf_w[g])
    );

    // Reference: occupancy as an integer, accepted beats pushed into the scoreboard.
    initial begin
      bit rd_m, wr_m;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          cnt = 0;
          ovf = 0;
          sb.delete();
        end else begin
          rd_m = (cnt != 0) && rdy[g];
          wr_m = vld[g] && ((cnt < int'(D)) || rd_m);
          if (wr_m) sb.push_back(dat[g]);
          else if (vld[g]) ovf = 1;
          cnt = cnt + (wr_m ? 1 : 0) - (rd_m ? 1 : 0);
        end
      end
    end

    initial begin
      logic [31:0] exp_d;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          check($sformatf("vld_o[%0d]", g), 32'(vldo_w[g]), 32'(cnt != 0));
          check($sformatf("count_o[%0d]", g), cnt_w[g], 32'(cnt));
          check($sformatf("stop_o[%0d]", g), 32'(stop_w[g]), 32'(cnt >= int'(D - Lat)));
          check($sformatf("ovf_o[%0d]", g), 32'(ovf_w[g]), 32'(ovf));
          check($sformatf("count_le_depth[%0d]", g), 32'(cnt_w[g] <= D), 32'd1);
          if (vldo_w[g] && rdy[g]) begin
            if (sb.size() == 0) begin
              check($sformatf("unexpected_beat[%0d]", g), data_w[g], 32'hxxxx_xxxx);
            end else begin
              exp_d = sb.pop_front();
              check($sformatf("data_o[%0d]", g), data_w[g], exp_d);
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst_n  = 1'b0;
    cyc(2);
    rst_n  = 1'b1;
    cyc(1);
  endtask

  // Push beats first..last back-to-back into instance 0.
  task automatic burst0(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      vld[0] = 1'b1;
      dat[0] = 32'(k);
      cyc(1);
    end
    vld[0] = 1'b0;
  endtask

  initial begin
    bit          dl_v[Lat];
    logic [31:0] dl_d[Lat];
    bit          issue;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
      rdy[i] = 1'b1;
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    check("idle_vld", 32'(vldo_w[0]), 32'd0);
    check("idle_stop", 32'(stop_w[0]), 32'd0);
    check("idle_count", cnt_w[0], 32'd0);
    check("idle_ovf", 32'(ovf_w[0]), 32'd0);

    // Single beat: visible one cycle later, gone the cycle after.
    vld[0] = 1'b1;
    dat[0] = 32'hA5A5_0001;
    cyc(1);
    vld[0] = 1'b0;
    check("single_vld", 32'(vldo_w[0]), 32'd1);
    check("single_data", data_w[0], 32'hA5A5_0001);
    cyc(1);
    check("single_drained", cnt_w[0], 32'd0);

    // Asynchronous reset with three beats held.
    rdy[0] = 1'b0;
    burst0(11, 13);
    check("pre_rst_count", cnt_w[0], 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", cnt_w[0], 32'd0);
    check("async_rst_vld", 32'(vldo_w[0]), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    cyc(3);
    check("post_rst_vld", 32'(vldo_w[0]), 32'd0);

    // Fill with a producer that stops Lat cycles after stop_o: exactly full, no loss.
    rdy[0] = 1'b0;
    burst0(1, 6);
    check("stop_at_6", 32'(stop_w[0]), 32'd1);
    burst0(7, 8);
    check("fill_count", cnt_w[0], 32'd8);
    check("fill_ovf", 32'(ovf_w[0]), 32'd0);

    // Full with simultaneous read and write across several pointer wraps.
    rdy[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      vld[0] = 1'b1;
      dat[0] = 32'(100 + k);
      cyc(1);
    end
    vld[0] = 1'b0;
    check("rw_full_ovf", 32'(ovf_w[0]), 32'd0);
    cyc(12);
    check("rw_drained", cnt_w[0], 32'd0);

    // Producer overruns by one beat: beat 9 is lost and ovf_o sticks.
    do_reset();
    rdy[0] = 1'b0;
    burst0(1, 9);
    check("ovr_count", cnt_w[0], 32'd8);
    check("ovr_ovf", 32'(ovf_w[0]), 32'd1);
    rdy[0] = 1'b1;
    cyc(12);
    check("ovr_drained", cnt_w[0], 32'd0);
    check("ovr_sticky", 32'(ovf_w[0]), 32'd1);

    // Randomized run on DEPTH=5 with a producer whose stop reaction is delayed by Lat cycles.
    do_reset();
    for (int i = 0; i < int'(Lat); i++) dl_v[i] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      issue  = ($urandom_range(0, 1) == 1) && !stop_w[1];
      vld[1] = dl_v[Lat-1];
      dat[1] = dl_d[Lat-1];
      for (int i = int'(Lat) - 1; i > 0; i--) begin
        dl_v[i] = dl_v[i-1];
        dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = issue;
      dl_d[0] = $urandom;
      rdy[1]  = ($urandom_range(0, 9) < 3);
      cyc(1);
    end
    for (int c = 0; c < int'(Lat); c++) begin
      vld[1] = dl_v[Lat-1];
      dat[1] = dl_d[Lat-1];
      for (int i = int'(Lat) - 1; i > 0; i--) begin
        dl_v[i] = dl_v[i-1];
        dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = 1'b0;
      cyc(1);
    end
    vld[1] = 1'b0;
    rdy[1] = 1'b1;
    cyc(10);
    check("rand_ovf", 32'(ovf_w[1]), 32'd0);
    check("rand_drained", cnt_w[1], 32'd0);
    check("sb0_empty", 32'(g_dut[0].sb.size()), 32'd0);
    check("sb1_empty", 32'(g_dut[1].sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
